// File: rtl/select_switch_unit_pkg.sv
// Shared constants and helpers for the select/switch datapath block.
package select_switch_unit_pkg;

    localparam int DEFAULT_SIZE       = 8;
    localparam int DEFAULT_DATA_WIDTH = 16;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

    // Bit offset of word i on a packed bus of width-bit words, word 0 in the LSBs.
    function automatic int unsigned word_offset(input int unsigned i, input int unsigned width);
        return i * width;
    endfunction

endpackage

// File: rtl/select_switch_unit_bit_select.sv
// SIZE:1 single-bit selector; an out-of-range select yields 0.
module bit_select
    import select_switch_unit_pkg::*;
#(
    parameter int SIZE      = DEFAULT_SIZE,
    parameter int SEL_WIDTH = clog2(SIZE)
) (
    input  logic [SEL_WIDTH-1:0] sel,
    input  logic [SIZE-1:0]      d,
    output logic                 y
);

    // Compare-per-source keeps out-of-range selects at 0 and never infers a latch.
    always_comb begin
        y = 1'b0;
        for (int unsigned i = 0; i < SIZE; i++) begin
            if (sel == SEL_WIDTH'(i)) begin
                y = d[i];
            end
        end
    end

endmodule

// File: rtl/select_switch_unit.sv
// Bit mux and word switch sharing one select, with en-gated registered copies.
module select_switch_unit
    import select_switch_unit_pkg::*;
#(
    parameter int SIZE       = DEFAULT_SIZE,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    localparam int SEL_WIDTH = clog2(SIZE)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [SEL_WIDTH-1:0]       S,
    input  logic [SIZE-1:0]            D,
    output logic                       Y,
    input  logic [SIZE*DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0]      data_out,
    input  logic                       en,
    output logic                       Y_q,
    output logic [DATA_WIDTH-1:0]      data_out_q,
    output logic                       sel_err
);

    logic [SIZE-1:0] lanes [DATA_WIDTH];

    // Transpose the word bus so lane j gathers bit j of every word.
    always_comb begin
        for (int unsigned j = 0; j < DATA_WIDTH; j++) begin
            for (int unsigned i = 0; i < SIZE; i++) begin
                lanes[j][i] = data_in[word_offset(i, DATA_WIDTH) + j];
            end
        end
    end

    bit_select #(
        .SIZE      (SIZE),
        .SEL_WIDTH (SEL_WIDTH)
    ) u_bit_mux (
        .sel (S),
        .d   (D),
        .y   (Y)
    );

    for (genvar j = 0; j < DATA_WIDTH; j++) begin : g_lane
        bit_select #(
            .SIZE      (SIZE),
            .SEL_WIDTH (SEL_WIDTH)
        ) u_lane (
            .sel (S),
            .d   (lanes[j]),
            .y   (data_out[j])
        );
    end

    assign sel_err = (int'(S) >= SIZE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Y_q        <= '0;
            data_out_q <= '0;
        end else if (en) begin
            Y_q        <= Y;
            data_out_q <= data_out;
        end
    end

endmodule

// File: tb/tb_select_switch_unit.sv
// Directed-vector bench for select_switch_unit (SIZE=8 and SIZE=3 instances).
module tb_select_switch_unit;

    logic         clk = 1'b0;
    logic         reset;
    logic         en;
    logic [2:0]   s8;
    logic [7:0]   d8;
    logic [127:0] data_in8;
    logic         y8, y_q8, err8;
    logic [15:0]  dout8, dout_q8;

    logic [1:0]   s3;
    logic [2:0]   d3;
    logic [47:0]  data_in3;
    logic         y3, y_q3, err3;
    logic [15:0]  dout3, dout_q3;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    select_switch_unit #(.SIZE(8), .DATA_WIDTH(16)) dut8 (
        .clk(clk), .reset(reset), .S(s8), .D(d8), .Y(y8), .data_in(data_in8),
        .data_out(dout8), .en(en), .Y_q(y_q8), .data_out_q(dout_q8), .sel_err(err8)
    );

    select_switch_unit #(.SIZE(3), .DATA_WIDTH(16)) dut3 (
        .clk(clk), .reset(reset), .S(s3), .D(d3), .Y(y3), .data_in(data_in3),
        .data_out(dout3), .en(en), .Y_q(y_q3), .data_out_q(dout_q3), .sel_err(err3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [2:0]  s;
        logic [7:0]  d;
        logic        y;
        logic [15:0] word;
        logic        err;
    } vec8_t;

    typedef struct {
        logic [1:0]  s;
        logic [2:0]  d;
        logic        y;
        logic [15:0] word;
        logic        err;
    } vec3_t;

    vec8_t v8 [9];
    vec3_t v3 [5];

    initial begin
        v8[0] = '{3'd0, 8'h01, 1'b1, 16'h0110, 1'b0};
        v8[1] = '{3'd1, 8'h02, 1'b1, 16'h0220, 1'b0};
        v8[2] = '{3'd2, 8'h04, 1'b1, 16'h0330, 1'b0};
        v8[3] = '{3'd3, 8'h08, 1'b1, 16'h0440, 1'b0};
        v8[4] = '{3'd4, 8'h10, 1'b1, 16'h0550, 1'b0};
        v8[5] = '{3'd5, 8'h20, 1'b1, 16'h0660, 1'b0};
        v8[6] = '{3'd6, 8'h40, 1'b1, 16'h0770, 1'b0};
        v8[7] = '{3'd7, 8'h80, 1'b1, 16'h0108, 1'b0};
        v8[8] = '{3'd3, 8'h01, 1'b0, 16'h0440, 1'b0};

        v3[0] = '{2'd0, 3'b001, 1'b1, 16'h0110, 1'b0};
        v3[1] = '{2'd1, 3'b010, 1'b1, 16'h0220, 1'b0};
        v3[2] = '{2'd2, 3'b100, 1'b1, 16'h0330, 1'b0};
        v3[3] = '{2'd3, 3'b111, 1'b0, 16'h0000, 1'b1};
        v3[4] = '{2'd1, 3'b101, 1'b0, 16'h0220, 1'b0};

        data_in8 = {16'h0108, 16'h0770, 16'h0660, 16'h0550,
                    16'h0440, 16'h0330, 16'h0220, 16'h0110};
        data_in3 = {16'h0330, 16'h0220, 16'h0110};
        reset = 1'b1;
        en    = 1'b0;
        s8 = '0; d8 = '0; s3 = '0; d3 = '0;

        #1;
        check("reset_y_q8", 32'(y_q8), 32'd0);
        check("reset_dout_q8", 32'(dout_q8), 32'd0);
        check("reset_dout_q3", 32'(dout_q3), 32'd0);

        for (int i = 0; i < 9; i++) begin
            s8 = v8[i].s;
            d8 = v8[i].d;
            #1;
            check($sformatf("y8[%0d]", i), 32'(y8), 32'(v8[i].y));
            check($sformatf("dout8[%0d]", i), 32'(dout8), 32'(v8[i].word));
            check($sformatf("err8[%0d]", i), 32'(err8), 32'(v8[i].err));
        end

        for (int i = 0; i < 5; i++) begin
            s3 = v3[i].s;
            d3 = v3[i].d;
            #1;
            check($sformatf("y3[%0d]", i), 32'(y3), 32'(v3[i].y));
            check($sformatf("dout3[%0d]", i), 32'(dout3), 32'(v3[i].word));
            check($sformatf("err3[%0d]", i), 32'(err3), 32'(v3[i].err));
        end

        // Registered path: capture with en, then hold with en low.
        @(negedge clk);
        reset = 1'b0;
        en = 1'b1; s8 = 3'd2; d8 = 8'h04;
        @(posedge clk); #1;
        check("capture_dout_q", 32'(dout_q8), 32'h0330);
        check("capture_y_q", 32'(y_q8), 32'd1);

        @(negedge clk);
        en = 1'b0; s8 = 3'd5; d8 = 8'h00;
        @(posedge clk); #1;
        check("hold_dout_q", 32'(dout_q8), 32'h0330);
        check("hold_y_q", 32'(y_q8), 32'd1);
        check("hold_dout_comb", 32'(dout8), 32'h0660);

        // Asynchronous reset between edges.
        #2 reset = 1'b1;
        #1;
        check("async_rst_y_q", 32'(y_q8), 32'd0);
        check("async_rst_dout_q", 32'(dout_q8), 32'd0);
        check("rst_comb_unaffected", 32'(dout8), 32'h0660);

        en = 1'b1; s8 = 3'd4; d8 = 8'h10;
        repeat (2) @(posedge clk);
        #1;
        check("rst_wins_dout_q", 32'(dout_q8), 32'd0);
        check("rst_wins_y_q", 32'(y_q8), 32'd0);

        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        check("release_dout_q", 32'(dout_q8), 32'h0550);
        check("release_y_q", 32'(y_q8), 32'd1);

        // Out-of-range select on SIZE=3 registers zeros.
        @(negedge clk);
        s3 = 2'd2; d3 = 3'b100;
        @(posedge clk); #1;
        check("q3_in_range", 32'(dout_q3), 32'h0330);
        @(negedge clk);
        s3 = 2'd3; d3 = 3'b111;
        @(posedge clk); #1;
        check("q3_out_of_range", 32'(dout_q3), 32'd0);
        check("y_q3_out_of_range", 32'(y_q3), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
